// File: rtl/dot_product_feeder.sv
// Operand sequencer for the dot_product unit: buffers one kernel and one image window,
// then streams element pairs with valid/first/last framing and ready back-pressure.
module dot_product_feeder #(
  parameter int size  = 8,
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             filter_wr_en,
  input  logic [width-1:0] filter_wr_data,
  input  logic             image_wr_en,
  input  logic [width-1:0] image_wr_data,
  input  logic             start,
  input  logic             out_ready,
  output logic [width-1:0] filterInput,
  output logic [width-1:0] imageInput,
  output logic             out_valid,
  output logic             out_first,
  output logic             out_last,
  output logic             filter_full,
  output logic             image_full,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(size + 1);
  localparam int IW = (size > 1) ? $clog2(size) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(size);
  localparam logic [IW-1:0] LAST_IDX = IW'(size - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    fcnt_q, fcnt_d;
  logic [CW-1:0]    icnt_q, icnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [width-1:0] fbuf_q [size];
  logic [width-1:0] fbuf_d [size];
  logic [width-1:0] ibuf_q [size];
  logic [width-1:0] ibuf_d [size];
  logic             xfer;

  assign out_valid   = (state_q == STREAM);
  assign xfer        = out_valid && out_ready;
  assign out_first   = out_valid && (idx_q == '0);
  assign out_last    = out_valid && (idx_q == LAST_IDX);
  assign filterInput = out_valid ? fbuf_q[idx_q] : '0;
  assign imageInput  = out_valid ? ibuf_q[idx_q] : '0;
  assign filter_full = (fcnt_q == FULL_CNT);
  assign image_full  = (icnt_q == FULL_CNT);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    icnt_d  = icnt_q;
    idx_d   = idx_q;
    fbuf_d  = fbuf_q;
    ibuf_d  = ibuf_q;
    case (state_q)
      IDLE: begin
        // Buffers only accept appends while idle; full flags lag the filling write by a cycle.
        if (filter_wr_en && !filter_full) begin
          fbuf_d[fcnt_q[IW-1:0]] = filter_wr_data;
          fcnt_d                 = fcnt_q + 1'b1;
        end
        if (image_wr_en && !image_full) begin
          ibuf_d[icnt_q[IW-1:0]] = image_wr_data;
          icnt_d                 = icnt_q + 1'b1;
        end
        if (start && filter_full && image_full) begin
          state_d = STREAM;
          idx_d   = '0;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        // Filter stays resident for the next window; only the image is released.
        icnt_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      icnt_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      icnt_q  <= icnt_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk) begin
    fbuf_q <= fbuf_d;
    ibuf_q <= ibuf_d;
  end

endmodule

// File: doc/dot_product_feeder.md
# dot_product_feeder

Operand sequencer that drives the input side of the `dot_product` unit. It buffers one filter kernel and one image window of `size` elements each. On `start` it streams the element pairs, one per accepted cycle, on `filterInput`/`imageInput`, with valid/first/last framing and downstream back-pressure. The filter buffer is weight-stationary: it is retained across windows, while the image buffer is released after each pass.

## Interface
- `size`, 8, elements per dot product (≥2)
- `width`, 8, bits per filter/image element
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `filter_wr_en`  in  1  append `filter_wr_data` to filter buffer
- `filter_wr_data`  in  width  filter element
- `image_wr_en`  in  1  append `image_wr_data` to image buffer
- `image_wr_data`  in  width  image element
- `start`  in  1  begin streaming one dot product
- `out_ready`  in  1  downstream accepts current pair
- `filterInput`  out  width  filter operand to dot_product
- `imageInput`  out  width  image operand to dot_product
- `out_valid`  out  1  pair on outputs is valid
- `out_first`  out  1  current pair is element 0
- `out_last`  out  1  current pair is element size-1
- `filter_full`  out  1  filter count == size
- `image_full`  out  1  image count == size
- `busy`  out  1  state is STREAM or DONE
- `done`  out  1  one-cycle pulse after last pair accepted

## Operation
- Two register buffers of `size`×`width`, each with a write count 0..size.
  - A write stores at index = count; count then increments.
- A write is ignored in either of these cases:
  - the count is already size;
  - the state is not IDLE.
- FSM states: IDLE, STREAM, DONE.
- IDLE → STREAM: `start`=1 with `filter_full` and `image_full` both 1.
  - Otherwise `start` is ignored (no error, no latch).
- STREAM:
  - Index `idx` starts at 0.
  - Outputs are registered: `filterInput`=filter[idx], `imageInput`=image[idx].
  - `out_first`=(idx==0), `out_last`=(idx==size-1).
  - Handshake: a transfer occurs when `out_valid`&`out_ready`.
    - On a transfer, `idx` increments.
    - Without a transfer, all outputs hold stable.
  - A transfer with `out_last`=1 moves the FSM to DONE.
- DONE (one cycle):
  - `done`=1, `out_valid`=0.
  - The image count is cleared to 0 and the filter count is retained.
  - Then → IDLE.
- When `out_valid`=0, `filterInput`, `imageInput`, `out_first` and `out_last` are driven to 0.
- Reset values:
  - FSM=IDLE; both counts=0; `idx`=0.
  - All outputs are 0, including the full flags, `busy` and `done`.
  - Buffer contents are don't-care.

## Timing
- A qualifying `start` in cycle T gives `out_valid`=1 with element 0 at T+1.
- With `out_ready` held at 1:
  - element k is presented in cycle T+1+k;
  - `done` is asserted at T+1+size;
  - the block is in IDLE at T+2+size.
- `out_ready` low for n cycles stretches the pass by n cycles. No element is skipped or duplicated.
- Full flags update the cycle after the write that fills the buffer.
  - A `start` in that same write cycle is ignored.
- In DONE, `image_full`=0 from the next cycle. A fresh image load may begin in the IDLE cycle after DONE.
- `reset` in any state (including mid-stream with `out_ready` low):
  - takes effect at the next edge;
  - `out_valid` drops;
  - both counts clear, so the filter must be reloaded;
  - no `done` pulse is generated.

## Test plan
- Load filter 07,05,01,02,02,05,03,04 and image 06,03,00,01,03,04,02,01, then `start` with `out_ready`=1.
  - Pairs (07,06)…(04,01) appear in 8 consecutive cycles.
  - `out_first` is 1 on the first pair and `out_last` on the 8th.
  - `done` pulses 1 cycle later.
- Same pass with `out_ready` low for 3 cycles while pair (01,00) is presented: (01,00) holds 3 extra cycles, then the sequence resumes at (02,01) and `done` comes 3 cycles late.
- `start` with only 7 image elements loaded is ignored (`busy` stays 0). A 9th filter write while `filter_full` is ignored: stream pair 0 is still 07.
- After `done`, load a new image 01×8 and restart without touching the filter. Stream shows filter 07..04 paired with 01. `image_full`=0 in the cycle after `done`.
- Writes during STREAM: `image_wr_en` with data FF mid-pass does not alter the stream or later passes.
- Assert `reset` at element 4 of a pass.
  - Next cycle: `out_valid`=0, `busy`=0, both full flags 0, no `done` pulse.
  - `start` is ignored until both buffers are reloaded.
